// File: rtl/vga_update_scheduler_pkg.sv
// Shared definitions for the VGA update scheduler.
//   state_e          : commit sequencer states
//   LOC_W/ORI_W/TGT_W: payload widths of the location, orientation and target words
//   V_ACTIVE_DEFAULT : first vertical-blank line of the 1024x768 timing
package vga_update_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        C_LOC = 2'd1,
        C_ORI = 2'd2,
        C_TGT = 2'd3
    } state_e;

    localparam int unsigned LOC_W            = 12;
    localparam int unsigned ORI_W            = 4;
    localparam int unsigned TGT_W            = 4;
    localparam int unsigned V_ACTIVE_DEFAULT = 768;

endpackage

// File: rtl/vga_update_scheduler_update_slot.sv
// One capture slot: shadow register plus pending flag.
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   valid_i     : load data_i into the shadow and mark pending
//   data_i      : new value
//   clear_i     : value is being committed this edge; drop pending
//   data_o      : shadow contents
//   pending_o   : a captured value awaits commit
//   overwrite_o : a pending value is being replaced before it was committed
module update_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic [W-1:0] data_o,
    output logic         pending_o,
    output logic         overwrite_o
);

    logic [W-1:0] shadow_q, shadow_d;
    logic         pending_q, pending_d;

    // A capture on the commit edge wins over the clear: the committer reads
    // the pre-edge shadow, and the fresh value stays pending for next frame.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (valid_i) begin
            shadow_d  = data_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // The value being displaced on a commit edge is consumed, not lost.
    assign overwrite_o = valid_i & pending_q & ~clear_i;
    assign data_o      = shadow_q;
    assign pending_o   = pending_q;

endmodule

// File: rtl/vga_update_scheduler.sv
// Buffers location / orientation / target updates and commits them to the
// vga_writer display registers only at the vertical-blank boundary, one slot
// per clock in priority order location, orientation, target.
// Optional feature macro: STALE_TIMEOUT_EN (frame counter driving stale).
//   vclock, reset        : pixel clock, synchronous active-low reset
//   hcount, vcount       : raster position from the timing generator
//   loc_in/move_in       : location and move command, captured by loc_valid
//   orient_in            : orientation, captured by orient_valid
//   target_in            : target, captured by target_valid
//   location, move_command, orientation, target_location : committed values
//   new_data             : one-cycle pulse on location commit
//   orientation_ready    : one-cycle pulse on orientation commit
//   pending              : {tgt, ori, loc} pending flags
//   overwrite_count      : saturating count of uncommitted values replaced
//   stale                : no location commit for STALE_FRAMES frames
module vga_update_scheduler
    import vga_update_scheduler_pkg::*;
#(
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEFAULT,
    parameter int unsigned STALE_FRAMES = 60,
    parameter int unsigned OVF_W        = 8
) (
    input  logic             vclock,
    input  logic             reset,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic [LOC_W-1:0] loc_in,
    input  logic [LOC_W-1:0] move_in,
    input  logic             loc_valid,
    input  logic [ORI_W-1:0] orient_in,
    input  logic             orient_valid,
    input  logic [TGT_W-1:0] target_in,
    input  logic             target_valid,
    output logic [LOC_W-1:0] location,
    output logic [LOC_W-1:0] move_command,
    output logic [ORI_W-1:0] orientation,
    output logic [TGT_W-1:0] target_location,
    output logic             new_data,
    output logic             orientation_ready,
    output logic [2:0]       pending,
    output logic [OVF_W-1:0] overwrite_count,
    output logic             stale
);

    state_e state_q, state_d;

    logic frame_tick;
    logic commit_loc, commit_ori, commit_tgt;

    logic [2*LOC_W-1:0] locmov_shadow;
    logic [ORI_W-1:0]   ori_shadow;
    logic [TGT_W-1:0]   tgt_shadow;
    logic               pend_loc, pend_ori, pend_tgt;
    logic               ovf_loc, ovf_ori, ovf_tgt;

    logic [LOC_W-1:0] location_q, move_q;
    logic [ORI_W-1:0] orientation_q;
    logic [TGT_W-1:0] target_q;
    logic             new_data_q, orient_rdy_q;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [1:0]       ovf_inc;
    logic [OVF_W:0]   ovf_sum;

    assign frame_tick = (vcount == 10'(V_ACTIVE)) && (hcount == '0);

    // Location and move command always travel together, so they share a slot.
    update_slot #(.W(2*LOC_W)) u_slot_loc (
        .clk_i       (vclock),
        .rst_ni      (reset),
        .valid_i     (loc_valid),
        .data_i      ({move_in, loc_in}),
        .clear_i     (commit_loc),
        .data_o      (locmov_shadow),
        .pending_o   (pend_loc),
        .overwrite_o (ovf_loc)
    );

    update_slot #(.W(ORI_W)) u_slot_ori (
        .clk_i       (vclock),
        .rst_ni      (reset),
        .valid_i     (orient_valid),
        .data_i      (orient_in),
        .clear_i     (commit_ori),
        .data_o      (ori_shadow),
        .pending_o   (pend_ori),
        .overwrite_o (ovf_ori)
    );

    update_slot #(.W(TGT_W)) u_slot_tgt (
        .clk_i       (vclock),
        .rst_ni      (reset),
        .valid_i     (target_valid),
        .data_i      (target_in),
        .clear_i     (commit_tgt),
        .data_o      (tgt_shadow),
        .pending_o   (pend_tgt),
        .overwrite_o (ovf_tgt)
    );

    // State register
    always_ff @(posedge vclock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: each transition picks the next pending slot in priority order
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (pend_loc) begin
                        state_d = C_LOC;
                    end else if (pend_ori) begin
                        state_d = C_ORI;
                    end else if (pend_tgt) begin
                        state_d = C_TGT;
                    end
                end
            end
            C_LOC:   state_d = pend_ori ? C_ORI : (pend_tgt ? C_TGT : IDLE);
            C_ORI:   state_d = pend_tgt ? C_TGT : IDLE;
            C_TGT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the commit happens on the edge that leaves each C_* state
    always_comb begin
        commit_loc = 1'b0;
        commit_ori = 1'b0;
        commit_tgt = 1'b0;
        case (state_q)
            C_LOC:   commit_loc = 1'b1;
            C_ORI:   commit_ori = 1'b1;
            C_TGT:   commit_tgt = 1'b1;
            default: ;
        endcase
    end

    // Up to three overwrites can land on one edge; saturate at all-ones.
    always_comb begin
        ovf_inc   = {1'b0, ovf_loc} + {1'b0, ovf_ori} + {1'b0, ovf_tgt};
        ovf_sum   = {1'b0, ovf_cnt_q} + {{(OVF_W-1){1'b0}}, ovf_inc};
        ovf_cnt_d = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    end

    always_ff @(posedge vclock) begin
        if (!reset) begin
            location_q    <= '0;
            move_q        <= '0;
            orientation_q <= '0;
            target_q      <= '0;
            new_data_q    <= 1'b0;
            orient_rdy_q  <= 1'b0;
            ovf_cnt_q     <= '0;
        end else begin
            new_data_q   <= commit_loc;
            orient_rdy_q <= commit_ori;
            ovf_cnt_q    <= ovf_cnt_d;
            if (commit_loc) begin
                location_q <= locmov_shadow[LOC_W-1:0];
                move_q     <= locmov_shadow[2*LOC_W-1:LOC_W];
            end
            if (commit_ori) begin
                orientation_q <= ori_shadow;
            end
            if (commit_tgt) begin
                target_q <= tgt_shadow;
            end
        end
    end

`ifdef STALE_TIMEOUT_EN
    localparam int unsigned STALE_W = (STALE_FRAMES < 1) ? 1 : $clog2(STALE_FRAMES + 1);

    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

    // Counter stops at the threshold; that is all stale needs to know.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (commit_loc) begin
            stale_cnt_d = '0;
        end else if (frame_tick && (stale_cnt_q < STALE_W'(STALE_FRAMES))) begin
            stale_cnt_d = stale_cnt_q + STALE_W'(1);
        end
    end

    always_ff @(posedge vclock) begin
        if (!reset) begin
            stale_cnt_q <= '0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign stale = (stale_cnt_q >= STALE_W'(STALE_FRAMES));
`else
    assign stale = 1'b0;
`endif

    assign location          = location_q;
    assign move_command      = move_q;
    assign orientation       = orientation_q;
    assign target_location   = target_q;
    assign new_data          = new_data_q;
    assign orientation_ready = orient_rdy_q;
    assign pending           = {pend_tgt, pend_ori, pend_loc};
    assign overwrite_count   = ovf_cnt_q;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Self-checking bench for vga_update_scheduler: directed scenarios followed by
// randomized frames, all compared each cycle against a timetable model.
module tb_vga_update_scheduler;

    localparam int unsigned STALE_N = 4;

    logic        vclock = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [11:0] loc_in, move_in;
    logic        loc_valid;
    logic [3:0]  orient_in;
    logic        orient_valid;
    logic [3:0]  target_in;
    logic        target_valid;
    logic [11:0] location, move_command;
    logic [3:0]  orientation, target_location;
    logic        new_data, orientation_ready;
    logic [2:0]  pending;
    logic [7:0]  overwrite_count;
    logic        stale;

    vga_update_scheduler #(
        .V_ACTIVE     (768),
        .STALE_FRAMES (STALE_N),
        .OVF_W        (8)
    ) dut (
        .vclock            (vclock),
        .reset             (reset),
        .hcount            (hcount),
        .vcount            (vcount),
        .loc_in            (loc_in),
        .move_in           (move_in),
        .loc_valid         (loc_valid),
        .orient_in         (orient_in),
        .orient_valid      (orient_valid),
        .target_in         (target_in),
        .target_valid      (target_valid),
        .location          (location),
        .move_command      (move_command),
        .orientation       (orientation),
        .target_location   (target_location),
        .new_data          (new_data),
        .orientation_ready (orientation_ready),
        .pending           (pending),
        .overwrite_count   (overwrite_count),
        .stale             (stale)
    );

    always #5 vclock = ~vclock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: slots hold value+pending; a frame tick while no commit
    // sequence is running books the pending slots onto consecutive edges.
    typedef struct {
        int slot;
        int at;
    } ev_t;

    ev_t         sched[$];
    int          edge_n = 0;
    logic [11:0] m_loc_sh, m_mov_sh, m_loc, m_mov;
    logic [3:0]  m_ori_sh, m_tgt_sh, m_ori, m_tgt;
    bit          m_pend[3];
    int          m_ovf;
    bit          m_nd, m_or;
    int          m_frames;

    task automatic model_reset();
        m_loc_sh = '0; m_mov_sh = '0; m_ori_sh = '0; m_tgt_sh = '0;
        m_loc = '0; m_mov = '0; m_ori = '0; m_tgt = '0;
        for (int s = 0; s < 3; s++) m_pend[s] = 1'b0;
        m_ovf = 0;
        m_frames = 0;
        sched.delete();
    endtask

    task automatic bump_ovf();
        if (m_ovf < 255) m_ovf++;
    endtask

    task automatic model_edge();
        bit idle_pre;
        bit loc_commit;
        bit tick;
        int k;
        edge_n++;
        m_nd = 1'b0;
        m_or = 1'b0;
        if (!reset) begin
            model_reset();
            return;
        end
        tick       = (vcount == 10'd768) && (hcount == 11'd0);
        idle_pre   = (sched.size() == 0);
        loc_commit = 1'b0;
        if (!idle_pre && sched[0].at == edge_n) begin
            case (sched[0].slot)
                0: begin m_loc = m_loc_sh; m_mov = m_mov_sh; m_nd = 1'b1; loc_commit = 1'b1; end
                1: begin m_ori = m_ori_sh; m_or = 1'b1; end
                default: m_tgt = m_tgt_sh;
            endcase
            m_pend[sched[0].slot] = 1'b0;
            void'(sched.pop_front());
        end
        if (tick && idle_pre) begin
            k = 0;
            for (int s = 0; s < 3; s++) begin
                if (m_pend[s]) begin
                    sched.push_back('{s, edge_n + 1 + k});
                    k++;
                end
            end
        end
        if (loc_commit) m_frames = 0;
        else if (tick && m_frames < 1000) m_frames++;
        if (loc_valid) begin
            if (m_pend[0]) bump_ovf();
            m_loc_sh = loc_in; m_mov_sh = move_in; m_pend[0] = 1'b1;
        end
        if (orient_valid) begin
            if (m_pend[1]) bump_ovf();
            m_ori_sh = orient_in; m_pend[1] = 1'b1;
        end
        if (target_valid) begin
            if (m_pend[2]) bump_ovf();
            m_tgt_sh = target_in; m_pend[2] = 1'b1;
        end
    endtask

    task automatic check_all();
        bit exp_stale;
`ifdef STALE_TIMEOUT_EN
        exp_stale = (m_frames >= STALE_N);
`else
        exp_stale = 1'b0;
`endif
        check_eq("location", location, m_loc);
        check_eq("move_command", move_command, m_mov);
        check_eq("orientation", orientation, m_ori);
        check_eq("target_location", target_location, m_tgt);
        check_eq("new_data", new_data, m_nd);
        check_eq("orientation_ready", orientation_ready, m_or);
        check_eq("pending", pending, {m_pend[2], m_pend[1], m_pend[0]});
        check_eq("overwrite_count", overwrite_count, m_ovf);
        check_eq("stale", stale, exp_stale);
    endtask

    // One clock: the DUT samples the current inputs at the edge, the model
    // applies the same inputs, outputs are compared 1 time unit later, then
    // strobes drop and the raster goes back to a non-trigger position.
    task automatic step();
        @(posedge vclock);
        #1;
        model_edge();
        check_all();
        loc_valid    = 1'b0;
        orient_valid = 1'b0;
        target_valid = 1'b0;
        vcount       = 10'd100;
        hcount       = 11'd5;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick();
        vcount = 10'd768;
        hcount = 11'd0;
        step();
    endtask

    task automatic set_loc(input logic [11:0] l, input logic [11:0] m);
        loc_in = l; move_in = m; loc_valid = 1'b1;
    endtask

    task automatic set_ori(input logic [3:0] o);
        orient_in = o; orient_valid = 1'b1;
    endtask

    task automatic set_tgt(input logic [3:0] t);
        target_in = t; target_valid = 1'b1;
    endtask

    initial begin
        model_reset();
        reset        = 1'b0;
        vcount       = 10'd100;
        hcount       = 11'd5;
        loc_in       = '0;
        move_in      = '0;
        orient_in    = '0;
        target_in    = '0;
        loc_valid    = 1'b0;
        orient_valid = 1'b0;
        target_valid = 1'b0;

        // Reset with a location strobe during it: nothing may be captured
        for (int i = 0; i < 3; i++) begin
            set_loc(12'hABC, 12'h123);
            step();
        end
        check_eq("rst_pending", pending, 3'b000);
        check_eq("rst_location", location, 12'h000);
        reset = 1'b1;
        step();
        tick();
        quiet(4);
        check_eq("rst_no_commit", location, 12'h000);

        // Single location commit, two edges after the tick cycle
        set_loc(12'h3A5, 12'h0F0);
        step();
        quiet(3);
        tick();
        step();
        check_eq("t2_location", location, 12'h3A5);
        check_eq("t2_move", move_command, 12'h0F0);
        check_eq("t2_new_data_hi", new_data, 1'b1);
        step();
        check_eq("t2_new_data_lo", new_data, 1'b0);
        check_eq("t2_pending", pending, 3'b000);
        quiet(3);

        // All three slots pending
        set_loc(12'h111, 12'h222);
        set_ori(4'h7);
        set_tgt(4'h2);
        step();
        quiet(2);
        tick();
        step();
        check_eq("t3_loc", location, 12'h111);
        check_eq("t3_nd", new_data, 1'b1);
        step();
        check_eq("t3_ori", orientation, 4'h7);
        check_eq("t3_ordy", orientation_ready, 1'b1);
        step();
        check_eq("t3_tgt", target_location, 4'h2);
        check_eq("t3_ordy_lo", orientation_ready, 1'b0);
        step();
        check_eq("t3_pending", pending, 3'b000);
        quiet(2);

        // Overwrite in one frame, then saturation
        set_loc(12'h010, 12'h001);
        step();
        set_loc(12'h020, 12'h002);
        step();
        check_eq("t4_ovf1", overwrite_count, 8'h01);
        tick();
        quiet(3);
        check_eq("t4_loc", location, 12'h020);
        for (int i = 0; i < 300; i++) begin
            set_loc(12'($urandom), 12'($urandom));
            step();
        end
        check_eq("t4_ovf_sat", overwrite_count, 8'hFF);
        tick();
        quiet(3);

        // Capture on the commit edge of the same slot
        set_loc(12'h044, 12'h404);
        step();
        quiet(2);
        tick();
        set_loc(12'h055, 12'h505);
        step();
        check_eq("t5_loc_old", location, 12'h044);
        check_eq("t5_pend_kept", pending[0], 1'b1);
        quiet(3);
        tick();
        quiet(2);
        check_eq("t5_loc_new", location, 12'h055);
        check_eq("t5_pending", pending, 3'b000);

        // Stale timeout from a clean reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            tick();
            quiet(2);
        end
`ifdef STALE_TIMEOUT_EN
        check_eq("t6_stale_set", stale, 1'b1);
`endif
        set_loc(12'h777, 12'h888);
        step();
        tick();
        step();
        check_eq("t6_stale_clr", stale, 1'b0);
        quiet(3);

        // Reset in the middle of a commit sequence
        set_loc(12'h9AB, 12'hCDE);
        set_ori(4'h5);
        set_tgt(4'hC);
        step();
        tick();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        quiet(5);
        check_eq("rst_mid_ori", orientation, 4'h0);

        // Randomized frames with near-miss raster positions
        for (int f = 0; f < 60; f++) begin
            int ncyc;
            ncyc = int'($urandom_range(2, 10));
            for (int c = 0; c < ncyc; c++) begin
                if ($urandom_range(0, 2) == 0) set_loc(12'($urandom), 12'($urandom));
                if ($urandom_range(0, 2) == 0) set_ori(4'($urandom));
                if ($urandom_range(0, 2) == 0) set_tgt(4'($urandom));
                if ($urandom_range(0, 1) == 0) begin
                    vcount = 10'd768;
                    hcount = 11'($urandom_range(1, 1343));
                end else begin
                    vcount = 10'($urandom_range(0, 767));
                    hcount = 11'($urandom_range(0, 1343));
                end
                step();
            end
            if ($urandom_range(0, 3) != 0) begin
                tick();
            end
            quiet(5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_update_scheduler.md
Name: vga_update_scheduler

Overview:
- Sits between the sensor/user front-ends (ultrasound location, IMU orientation, target selector) and vga_writer.
- Buffers asynchronous-to-frame updates from three requesters and commits them to the display registers only at the vertical-blank boundary, so vga_writer renders one consistent state per frame.
- Serialises the commits in fixed priority (location, orientation, target), one per clock, and pulses vga_writer's new_data / orientation_ready strobes.

Parameters:
- V_ACTIVE, 768: vcount value of the first blank line; the commit trigger line.
- STALE_FRAMES, 60: frames without a location commit before stale asserts (optional feature only).
- OVF_W, 8: width of the saturating overwrite counter.

Ports:
- vclock  in  1  pixel clock, the only clock.
- reset  in  1  synchronous, active-low reset; sampled on the vclock rising edge.
- hcount  in  11  horizontal pixel count from the xvga timing generator.
- vcount  in  10  vertical line count from the xvga timing generator.
- loc_in  in  12  new location word.
- move_in  in  12  new move_command word.
- loc_valid  in  1  one-cycle strobe; captures loc_in and move_in.
- orient_in  in  4  new orientation.
- orient_valid  in  1  one-cycle strobe; captures orient_in.
- target_in  in  4  new target_location.
- target_valid  in  1  one-cycle strobe; captures target_in.
- location  out  12  committed location, to vga_writer.
- move_command  out  12  committed move command, to vga_writer.
- orientation  out  4  committed orientation, to vga_writer.
- target_location  out  4  committed target, to vga_writer.
- new_data  out  1  one-cycle pulse when location and move_command are committed.
- orientation_ready  out  1  one-cycle pulse when orientation is committed.
- pending  out  3  {tgt, ori, loc} pending flags.
- overwrite_count  out  OVF_W  saturating count of pending values overwritten before commit.
- stale  out  1  location not refreshed within STALE_FRAMES frames.

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs go to 0, pending clears, FSM goes to IDLE.
  - A reset during a commit sequence abandons it; no strobe fires after reset.
- Capture slots (one per requester): each is a shadow register plus a pending flag.
  - A valid strobe loads the shadow and sets pending.
  - If pending was already set, the new value overwrites the old one and overwrite_count increments, saturating at all-ones.
  - Simultaneous strobes on different slots each count separately.
- frame_tick = (vcount==V_ACTIVE && hcount==0). This is true for exactly one cycle per frame.
- FSM states: IDLE, C_LOC, C_ORI, C_TGT.
  - IDLE: on frame_tick, go to the first pending slot in order loc, ori, tgt. If none is pending, stay in IDLE.
  - C_LOC: at the edge, location<=loc shadow, move_command<=move shadow, new_data<=1, clear loc pending. Next state is the next pending slot (ori, then tgt), otherwise IDLE.
  - C_ORI: orientation<=shadow, orientation_ready<=1, clear ori pending. Next state is C_TGT if tgt pending, otherwise IDLE.
  - C_TGT: target_location<=shadow, clear tgt pending. Next state is IDLE; there is no strobe for target.
- Timing:
  - Pending flags are evaluated at each transition.
  - Strobes are high for exactly one cycle and are 0 in every other cycle.
  - With all three slots pending, the location outputs update 2 edges after the frame_tick cycle, orientation 3 edges after, target 4 edges after.
- Capture and commit on the same edge for the same slot: the commit uses the pre-edge shadow. The shadow then takes the new value, pending stays set, and the value commits next frame. This is not counted as an overwrite.
- A frame_tick outside IDLE is ignored. This cannot occur with legal timing.
- Committed outputs hold their values between commits.

Optional Feature:
- Macro: STALE_TIMEOUT_EN.
- Defined:
  - A saturating frame counter increments on each frame_tick.
  - The counter clears on the C_LOC commit edge.
  - stale = (counter >= STALE_FRAMES).
  - Reset clears the counter, so stale is 0 after reset until STALE_FRAMES frames pass with no location commit.
- Undefined: no counter is built and stale is tied to 0.

Decomposition:
- Shared package/include:
  - FSM state encodings.
  - Width constants LOC_W=12, ORI_W=4, TGT_W=4.
  - Default V_ACTIVE.
- One natural sub-module, update_slot (parameter W):
  - Contains the shadow register and pending flag.
  - Outputs an overwrite pulse and takes a commit-clear input.
  - Instantiated three times; the move_command slot is merged with the location slot as a 24-bit instance.

Test Plan:
1. Reset: drive reset=0 for 3 cycles with loc_valid pulsed -> all outputs 0, pending=0, no strobe. Release reset, then apply a frame_tick -> no commit.
2. Single location: loc_in=12'h3A5, move_in=12'h0F0, loc_valid pulse at vcount=100, then tick at vcount=768, hcount=0 -> location=3A5 and move_command=0F0 two edges after the tick, new_data high for exactly 1 cycle, pending=0.
3. All three pending: loc 12'h111, orient 4'h7, target 4'h2 before the tick -> location updates with new_data at tick+2, orientation=7 with orientation_ready at tick+3, target=2 at tick+4, FSM back in IDLE at tick+5.
4. Overwrite: two loc_valid pulses (12'h010 then 12'h020) in one frame -> overwrite_count=1, committed location=020. 300 overwrites -> overwrite_count=8'hFF.
5. Collision: loc_valid with 12'h055 on the C_LOC edge, after an earlier pending 12'h044 -> 044 commits this frame, pending[0] stays 1, 055 commits next frame.
6. With STALE_TIMEOUT_EN, STALE_FRAMES=4: 4 ticks with no location -> stale=1 after the 4th tick. A location commit -> stale=0 the next cycle.
